// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter for the register file write port
//
// Purpose:
//   Shares the single register-file write port between the ALU writeback and
//   the memory-load writeback. Conflicts are resolved round-robin, and the
//   write port is driven from registers one cycle after acceptance. Writes to
//   register 0 are accepted and then dropped.
//
// Ports:
//   clk, areset_n           clock, asynchronous active-low reset
//   flush                   blocks every acceptance in the current cycle
//   alu_valid/reg/data      ALU writeback request
//   alu_ready               ALU request accepted this cycle (combinational)
//   mem_valid/reg/data      load writeback request
//   mem_ready               load request accepted this cycle (combinational)
//   rf_write_enable/reg/data  registered drive of the register file write port
//   conflict_count          saturating count of unflushed cycles with both valid

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  flush,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_reg,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_reg,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t last_grant;
  logic   conflict;
  logic   alu_accept;
  logic   mem_accept;

  // Ready depends only on the valids, flush and the round-robin pointer, so
  // it can never be influenced by the losing requester's reg or data.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    conflict  = alu_valid && mem_valid && !flush;
    if (!flush) begin
      if (alu_valid && mem_valid) begin
        alu_ready = (last_grant == GRANT_MEM);
        mem_ready = (last_grant == GRANT_ALU);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_accept = alu_valid && alu_ready;
  assign mem_accept = mem_valid && mem_ready;

  // The write enable is qualified with reg != 0 at acceptance time, which is
  // what keeps register 0 from ever being written.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
      last_grant      <= GRANT_MEM;
    end else if (alu_accept) begin
      rf_write_enable <= (alu_reg != '0);
      rf_write_reg    <= alu_reg;
      rf_write_data   <= alu_data;
      last_grant      <= GRANT_ALU;
    end else if (mem_accept) begin
      rf_write_enable <= (mem_reg != '0);
      rf_write_reg    <= mem_reg;
      rf_write_data   <= mem_data;
      last_grant      <= GRANT_MEM;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      conflict_count <= '0;
    end else if (conflict && (conflict_count != {CNT_WIDTH{1'b1}})) begin
      conflict_count <= conflict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        flush;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [15:0] conflict_count;

  logic        alu_ready_s;
  logic        mem_ready_s;
  logic        rf_write_enable_s;
  logic [4:0]  rf_write_reg_s;
  logic [31:0] rf_write_data_s;
  logic [3:0]  conflict_count_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .areset_n(areset_n), .flush(flush),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .conflict_count(conflict_count)
  );

  regfile_wb_arbiter #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .areset_n(areset_n), .flush(flush),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready_s),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready_s),
    .rf_write_enable(rf_write_enable_s), .rf_write_reg(rf_write_reg_s),
    .rf_write_data(rf_write_data_s), .conflict_count(conflict_count_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    alu_valid = 1'b0;
    alu_reg   = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_reg   = '0;
    mem_data  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    areset_n = 1'b0;
    step();
    step();
    areset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b1;
    idle_inputs();
    #2;
    areset_n = 1'b0;
    #1;
    n_vec++;
    if (rf_write_enable !== 1'b0 || rf_write_reg !== 5'd0 || rf_write_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_port: we=%b reg=%0d data=%h, expected 0/0/0", rf_write_enable, rf_write_reg, rf_write_data);
    end
    n_vec++;
    if (conflict_count !== 16'd0 || conflict_count_s !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d/%0d, expected 0/0", conflict_count, conflict_count_s);
    end
    apply_reset();
  endtask

  task automatic test_single_alu();
    apply_reset();
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_ready: alu_ready=%b mem_ready=%b, expected 1/0", alu_ready, mem_ready);
    end
    step();
    alu_valid = 1'b0;
    n_vec++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd3 || rf_write_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL alu_write: we=%b reg=%0d data=%h, expected 1/3/deadbeef", rf_write_enable, rf_write_reg, rf_write_data);
    end
    step();
    n_vec++;
    if (rf_write_enable !== 1'b0 || rf_write_reg !== 5'd3) begin
      n_bad++;
      $display("FAIL alu_idle: we=%b reg=%0d, expected 0 with reg held at 3", rf_write_enable, rf_write_reg);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_reg [4];
    exp_reg[0] = 5'd5; exp_reg[1] = 5'd6; exp_reg[2] = 5'd5; exp_reg[3] = 5'd6;
    apply_reset();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (alu_ready !== (exp_reg[i] == 5'd5) || mem_ready !== (exp_reg[i] == 5'd6)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: alu_ready=%b mem_ready=%b, expected winner reg %0d", i, alu_ready, mem_ready, exp_reg[i]);
      end
      step();
      n_vec++;
      if (rf_write_enable !== 1'b1 || rf_write_reg !== exp_reg[i] ||
          rf_write_data !== ((exp_reg[i] == 5'd5) ? 32'h11 : 32'h22)) begin
        n_bad++;
        $display("FAIL rr_write[%0d]: we=%b reg=%0d data=%h, expected reg %0d", i, rf_write_enable, rf_write_reg, rf_write_data, exp_reg[i]);
      end
    end
    idle_inputs();
    n_vec++;
    if (conflict_count !== 16'd4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d, expected 4", conflict_count);
    end
  endtask

  task automatic test_reg_zero();
    apply_reset();
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_ready: mem_ready=%b alu_ready=%b, expected 1/0", mem_ready, alu_ready);
    end
    step();
    mem_valid = 1'b0;
    n_vec++;
    if (rf_write_enable !== 1'b0 || rf_write_reg !== 5'd0) begin
      n_bad++;
      $display("FAIL zero_write: we=%b reg=%0d, expected 0/0", rf_write_enable, rf_write_reg);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    flush = 1'b1;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h22;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_ready[%0d]: alu_ready=%b mem_ready=%b, expected 0/0", i, alu_ready, mem_ready);
      end
      step();
      n_vec++;
      if (rf_write_enable !== 1'b0 || conflict_count !== 16'd0) begin
        n_bad++;
        $display("FAIL flush_hold[%0d]: we=%b count=%0d, expected 0/0", i, rf_write_enable, conflict_count);
      end
    end
    flush = 1'b0;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_release: alu_ready=%b mem_ready=%b, expected 1/0", alu_ready, mem_ready);
    end
    step();
    idle_inputs();
    n_vec++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd5 || conflict_count !== 16'd1) begin
      n_bad++;
      $display("FAIL flush_after: we=%b reg=%0d count=%0d, expected 1/5/1", rf_write_enable, rf_write_reg, conflict_count);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h22;
    step();
    mem_valid = 1'b0;
    alu_reg = 5'd7; alu_data = 32'h1234;
    step();
    n_vec++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd7 || rf_write_data !== 32'h1234 || conflict_count !== 16'd1) begin
      n_bad++;
      $display("FAIL areset_pre: we=%b reg=%0d data=%h count=%0d, expected 1/7/1234/1", rf_write_enable, rf_write_reg, rf_write_data, conflict_count);
    end
    #2;
    areset_n = 1'b0;
    #1;
    n_vec++;
    if (rf_write_enable !== 1'b0 || conflict_count !== 16'd0) begin
      n_bad++;
      $display("FAIL areset_async: we=%b count=%0d, expected 0/0", rf_write_enable, conflict_count);
    end
    step();
    n_vec++;
    if (rf_write_enable !== 1'b0 || rf_write_reg !== 5'd0) begin
      n_bad++;
      $display("FAIL areset_noaccept: we=%b reg=%0d, expected 0/0", rf_write_enable, rf_write_reg);
    end
    areset_n = 1'b1;
    mem_valid = 1'b1;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_rr: alu_ready=%b mem_ready=%b, expected 1/0", alu_ready, mem_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_saturate();
    apply_reset();
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hA;
    mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'hB;
    for (int i = 0; i < 15; i++) step();
    n_vec++;
    if (conflict_count_s !== 4'hF) begin
      n_bad++;
      $display("FAIL sat_reach: got %h, expected f", conflict_count_s);
    end
    for (int i = 0; i < 5; i++) step();
    idle_inputs();
    n_vec++;
    if (conflict_count_s !== 4'hF || conflict_count !== 16'd20) begin
      n_bad++;
      $display("FAIL sat_hold: small=%h wide=%0d, expected f/20", conflict_count_s, conflict_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_reg_zero();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
